multimode_register: RTL and testbench

- Parametrised successor to the single-bit negative-edge D flip-flop used throughout the processor datapath.
- Holds a WIDTH-bit value with synchronous clear and preset, a load/hold enable, and an operation select: parallel load, shifts, rotate, increment and decrement.
- Produces a registered carry/shift-out flag and a zero flag.
- Serves as the common building block for the PC, shift unit staging and loop counters.

---
 rtl/multimode_register.sv | 106 ++++++++++
 tb/tb_multimode_register.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multimode_register.sv
// rtl/multimode_register.sv - WIDTH-bit falling-edge register with load, shift, rotate, count, clear and preset
// Every state update happens on negedge clk; zero and sout are combinational views of q.
module multimode_register #(
  parameter int                WIDTH        = 8,
  parameter logic [WIDTH-1:0]  PRESET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]  INIT_VALUE   = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic             sout
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ASR  = 3'd4,
    M_INC  = 3'd5,
    M_DEC  = 3'd6,
    M_ROL  = 3'd7
  } mode_e;

  // Power-on contents; the X-scrub below covers any simulator that ignores this.
  logic [WIDTH-1:0] q_q     = INIT_VALUE;
  logic             carry_q = 1'b0;
  logic [WIDTH-1:0] q_d;
  logic             carry_d;
  logic [WIDTH:0]   inc_w;

  assign inc_w = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if ($isunknown(q_q)) begin
      q_d     = '0;
      carry_d = 1'b0;
    end else if (clr) begin
      q_d     = '0;
      carry_d = 1'b0;
    end else if (pr) begin
      q_d     = PRESET_VALUE;
      carry_d = 1'b0;
    end else if (ena) begin
      case (mode_e'(mode))
        M_HOLD: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        M_LOAD: begin
          q_d     = d;
          carry_d = 1'b0;
        end
        M_SHL: begin
          q_d     = {q_q[WIDTH-2:0], sin};
          carry_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d     = {sin, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        M_ASR: begin
          q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        M_INC: begin
          q_d     = inc_w[WIDTH-1:0];
          carry_d = inc_w[WIDTH];
        end
        M_DEC: begin
          // Borrow only out of zero; the subtraction itself wraps modulo 2^WIDTH.
          q_d     = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
          carry_d = (q_q == '0);
        end
        M_ROL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    q_q     <= q_d;
    carry_q <= carry_d;
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign zero  = (q_q == '0);
  assign sout  = ((mode == 3'd2) || (mode == 3'd7)) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_multimode_register.sv
// tb/tb_multimode_register.sv - directed scoreboard bench for multimode_register (WIDTH=8)
module tb_multimode_register;

  logic       clk = 1'b1;
  logic       clr = 1'b0;
  logic       pr = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       sin = 1'b0;
  logic [7:0] q;
  logic       carry;
  logic       zero;
  logic       sout;

  int tests = 0;
  int fails = 0;
  logic x_seen;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];

  multimode_register #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr   (clr),
    .pr    (pr),
    .ena   (ena),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .carry (carry),
    .zero  (zero),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [7:0] eq, input logic ec);
    exp_t e;
    e.tag = tag;
    e.q   = eq;
    e.c   = ec;
    e.z   = (eq == 8'h00);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      tests++;
      assert (q === e.q) else begin
        fails++;
        $error("FAIL %s.q observed=%h expected=%h", e.tag, q, e.q);
      end
      tests++;
      assert (carry === e.c) else begin
        fails++;
        $error("FAIL %s.carry observed=%b expected=%b", e.tag, carry, e.c);
      end
      tests++;
      assert (zero === e.z) else begin
        fails++;
        $error("FAIL %s.zero observed=%b expected=%b", e.tag, zero, e.z);
      end
    end
  endtask

  task automatic check_sout(input string tag, input logic es);
    tests++;
    assert (sout === es) else begin
      fails++;
      $error("FAIL %s.sout observed=%b expected=%b", tag, sout, es);
    end
  endtask

  // One falling edge with the currently driven inputs, then compare against the scoreboard.
  task automatic edge_step(input string tag, input logic [7:0] eq, input logic ec);
    push_exp(tag, eq, ec);
    @(negedge clk);
    #1;
    check_out();
  endtask

  task automatic do_load(input logic [7:0] v);
    ena = 1'b1; mode = 3'd1; d = v;
    edge_step("load", v, 1'b0);
  endtask

  initial begin
    // Reset and priority
    clr = 1'b1; pr = 1'b1;
    edge_step("clr_over_pr", 8'h00, 1'b0);
    check_sout("clr_sout", 1'b0);
    clr = 1'b0;
    edge_step("preset", 8'hFF, 1'b0);
    pr = 1'b0;
    ena = 1'b1; mode = 3'd1; d = 8'h00;
    push_exp("posedge_only", 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    check_out();
    ena = 1'b0;

    // Load and hold
    do_load(8'hA5);
    ena = 1'b0; mode = 3'd5; d = 8'h3C;
    for (int i = 0; i < 3; i++) edge_step("ena_low_hold", 8'hA5, 1'b0);

    // Shifts and rotate
    do_load(8'h81);
    mode = 3'd2; sin = 1'b0;
    edge_step("shl", 8'h02, 1'b1);
    mode = 3'd3; sin = 1'b1;
    edge_step("shr", 8'h81, 1'b0);
    do_load(8'h80);
    mode = 3'd4; sin = 1'b0;
    edge_step("asr", 8'hC0, 1'b0);
    do_load(8'h81);
    mode = 3'd7;
    edge_step("rol", 8'h03, 1'b1);
    check_sout("rol_sout_msb", 1'b0);
    ena = 1'b0; mode = 3'd3;
    #1;
    check_sout("shr_sout_lsb", 1'b1);

    // Counter wrap
    do_load(8'hFE);
    mode = 3'd5;
    edge_step("inc_fe", 8'hFF, 1'b0);
    edge_step("inc_wrap", 8'h00, 1'b1);
    edge_step("inc_after_wrap", 8'h01, 1'b0);
    do_load(8'h01);
    mode = 3'd6;
    edge_step("dec_to_zero", 8'h00, 1'b0);
    edge_step("dec_borrow", 8'hFF, 1'b1);
    ena = 1'b0; mode = 3'd5;
    edge_step("carry_hold", 8'hFF, 1'b1);
    ena = 1'b1; mode = 3'd0;
    edge_step("mode_hold", 8'hFF, 1'b1);

    // Reset mid-count
    do_load(8'h10);
    mode = 3'd5;
    edge_step("count_1", 8'h11, 1'b0);
    edge_step("count_2", 8'h12, 1'b0);
    clr = 1'b1;
    edge_step("clr_mid_count", 8'h00, 1'b0);
    clr = 1'b0;
    edge_step("count_resume", 8'h01, 1'b0);

    // Preset beats an enabled operation
    pr = 1'b1;
    edge_step("pr_over_inc", 8'hFF, 1'b0);
    pr = 1'b0;

    // X-scrub: a 2-state simulator cannot hold X, in which case the load lands at once
    force dut.q_q = 8'hxx;
    #1;
    release dut.q_q;
    x_seen = $isunknown(q);
    ena = 1'b1; mode = 3'd1; d = 8'h55;
    edge_step("xscrub_1", x_seen ? 8'h00 : 8'h55, 1'b0);
    edge_step("xscrub_2", 8'h55, 1'b0);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
